// File: rtl/uarch_pkg.sv
// rtl/uarch_pkg.sv - shared micro-architecture widths and store-queue entry types
package uarch_pkg;

    localparam int TAG_WIDTH  = 4;
    localparam int PIPE_WIDTH = 2;

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_DONE    = 2'd2
    } entry_state_t;

    typedef struct packed {
        entry_state_t         state;
        logic [TAG_WIDTH-1:0] tag;
    } stq_entry_t;

endpackage

// File: rtl/store_commit_ctrl.sv
// rtl/store_commit_ctrl.sv - grants head-of-ROB stores to the store unit and tracks them until retire
module store_commit_ctrl
    import uarch_pkg::*;
#(
    parameter int STQ_DEPTH = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [TAG_WIDTH-1:0]             rob_head,
    input  logic [PIPE_WIDTH-1:0]            head_valid,
    input  logic [PIPE_WIDTH-1:0]            head_is_store,
    input  logic [PIPE_WIDTH-1:0]            head_ready,
    input  logic                             store_done_valid,
    input  logic [TAG_WIDTH-1:0]             store_done_tag,
    input  logic [PIPE_WIDTH-1:0]            rob_retire,
    output logic [TAG_WIDTH-1:0]             commit_store_ids [PIPE_WIDTH],
    output logic [PIPE_WIDTH-1:0]            commit_store_vals,
    output logic [PIPE_WIDTH-1:0]            store_retire_rdy,
    output logic [$clog2(STQ_DEPTH+1)-1:0]   stq_count,
    output logic                             stq_full
);

    localparam int CW = $clog2(STQ_DEPTH + 1);

    stq_entry_t             ent   [STQ_DEPTH];
    stq_entry_t             ent_n [STQ_DEPTH];
    logic [TAG_WIDTH-1:0]   slot_tag [PIPE_WIDTH];
    logic [PIPE_WIDTH-1:0]  tracked;
    logic [PIPE_WIDTH-1:0]  done_hit;
    logic [STQ_DEPTH-1:0]   first_free;
    logic [STQ_DEPTH-1:0]   second_free;
    logic [CW-1:0]          nfree;
    logic [CW-1:0]          nbusy;
    logic                   elig0;
    logic                   elig1;
    logic                   slot0_ok;
    logic [PIPE_WIDTH-1:0]  grant;

    always_comb begin
        for (int i = 0; i < PIPE_WIDTH; i++) begin
            slot_tag[i] = rob_head + TAG_WIDTH'(i);
        end
    end

    always_comb begin
        tracked  = '0;
        done_hit = '0;
        for (int i = 0; i < PIPE_WIDTH; i++) begin
            for (int e = 0; e < STQ_DEPTH; e++) begin
                if (ent[e].state != ST_FREE && ent[e].tag == slot_tag[i]) tracked[i] = 1'b1;
                if (ent[e].state == ST_DONE && ent[e].tag == slot_tag[i]) done_hit[i] = 1'b1;
            end
        end
    end

    // Free masks reflect registered state only, so entries freed this cycle are not reusable yet.
    always_comb begin
        nfree       = '0;
        nbusy       = '0;
        first_free  = '0;
        second_free = '0;
        for (int e = 0; e < STQ_DEPTH; e++) begin
            if (ent[e].state == ST_FREE) begin
                if (nfree == CW'(0))      first_free[e]  = 1'b1;
                else if (nfree == CW'(1)) second_free[e] = 1'b1;
                nfree = nfree + CW'(1);
            end else begin
                nbusy = nbusy + CW'(1);
            end
        end
    end

    always_comb begin
        elig0 = head_valid[0] & head_is_store[0] & head_ready[0] & ~tracked[0] & (|first_free);
        slot0_ok = (head_valid[0] & ~head_is_store[0]) | tracked[0] | elig0;
        elig1 = head_valid[1] & head_is_store[1] & head_ready[1] & ~tracked[1] & (|first_free)
              & slot0_ok & (~elig0 | (|second_free));
        grant = {elig1, elig0} & {PIPE_WIDTH{~(rst | flush)}};
    end

    assign store_retire_rdy = head_valid & head_is_store & done_hit;
    assign stq_count        = nbusy;
    assign stq_full         = (nbusy == CW'(STQ_DEPTH));

    always_comb begin
        for (int e = 0; e < STQ_DEPTH; e++) begin
            ent_n[e] = ent[e];
            if (grant[0] && first_free[e]) begin
                ent_n[e] = '{state: ST_GRANTED, tag: slot_tag[0]};
            end else if (grant[1] && (grant[0] ? second_free[e] : first_free[e])) begin
                ent_n[e] = '{state: ST_GRANTED, tag: slot_tag[1]};
            end else if (ent[e].state == ST_GRANTED && store_done_valid
                         && ent[e].tag == store_done_tag) begin
                ent_n[e].state = ST_DONE;
            end else if (ent[e].state == ST_DONE) begin
                for (int i = 0; i < PIPE_WIDTH; i++) begin
                    if (rob_retire[i] && ent[e].tag == slot_tag[i]) ent_n[e].state = ST_FREE;
                end
            end
            if (rst || flush) begin
                ent_n[e] = '{state: ST_FREE, tag: '0};
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < STQ_DEPTH; e++) begin
            ent[e] <= ent_n[e];
        end
        commit_store_vals <= grant;
        for (int i = 0; i < PIPE_WIDTH; i++) begin
            commit_store_ids[i] <= grant[i] ? slot_tag[i] : '0;
        end
    end

endmodule

// File: tb/tb_store_commit_ctrl.sv
// tb/tb_store_commit_ctrl.sv - directed self-checking bench for store_commit_ctrl
module tb_store_commit_ctrl;
    import uarch_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic [TAG_WIDTH-1:0]   rob_head;
    logic [PIPE_WIDTH-1:0]  head_valid, head_is_store, head_ready;
    logic                   store_done_valid;
    logic [TAG_WIDTH-1:0]   store_done_tag;
    logic [PIPE_WIDTH-1:0]  rob_retire;
    logic [TAG_WIDTH-1:0]   commit_store_ids [PIPE_WIDTH];
    logic [PIPE_WIDTH-1:0]  commit_store_vals;
    logic [PIPE_WIDTH-1:0]  store_retire_rdy;
    logic [2:0]             stq_count;
    logic                   stq_full;

    int checks = 0;
    int failures = 0;

    store_commit_ctrl #(.STQ_DEPTH(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .rob_head(rob_head),
        .head_valid(head_valid), .head_is_store(head_is_store), .head_ready(head_ready),
        .store_done_valid(store_done_valid), .store_done_tag(store_done_tag),
        .rob_retire(rob_retire), .commit_store_ids(commit_store_ids),
        .commit_store_vals(commit_store_vals), .store_retire_rdy(store_retire_rdy),
        .stq_count(stq_count), .stq_full(stq_full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; rob_head = '0;
        head_valid = '0; head_is_store = '0; head_ready = '0;
        store_done_valid = 1'b0; store_done_tag = '0; rob_retire = '0;
    endtask

    task automatic set_head(input logic [TAG_WIDTH-1:0] h, input logic [1:0] v,
                            input logic [1:0] s, input logic [1:0] r);
        rob_head = h; head_valid = v; head_is_store = s; head_ready = r;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic fill4();
        set_head(4'd0, 2'b11, 2'b11, 2'b11);
        tick();
        set_head(4'd2, 2'b11, 2'b11, 2'b11);
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        set_head(4'd1, 2'b11, 2'b11, 2'b11);
        rst = 1'b1;
        tick();
        checks++; if (commit_store_vals !== 2'b00) begin failures++; $display("FAIL reset_vals got=%b exp=00", commit_store_vals); end
        checks++; if (commit_store_ids[0] !== 4'd0 || commit_store_ids[1] !== 4'd0) begin failures++; $display("FAIL reset_ids got=%0d,%0d exp=0,0", commit_store_ids[1], commit_store_ids[0]); end
        checks++; if (stq_count !== 3'd0 || stq_full !== 1'b0) begin failures++; $display("FAIL reset_count got=%0d/%b exp=0/0", stq_count, stq_full); end
        rst = 1'b0;
        fill4();
        set_head(4'd9, 2'b11, 2'b11, 2'b11);
        rst = 1'b1;
        tick();
        checks++; if (commit_store_vals !== 2'b00 || stq_count !== 3'd0) begin failures++; $display("FAIL reset_midop got=%b/%0d exp=00/0", commit_store_vals, stq_count); end
        idle();
    endtask

    task automatic test_dual_grant();
        do_reset();
        set_head(4'd7, 2'b11, 2'b11, 2'b11);
        tick();
        checks++; if (commit_store_vals !== 2'b11) begin failures++; $display("FAIL dual_vals got=%b exp=11", commit_store_vals); end
        checks++; if (commit_store_ids[1] !== 4'd8 || commit_store_ids[0] !== 4'd7) begin failures++; $display("FAIL dual_ids got=%0d,%0d exp=8,7", commit_store_ids[1], commit_store_ids[0]); end
        checks++; if (stq_count !== 3'd2) begin failures++; $display("FAIL dual_count got=%0d exp=2", stq_count); end
        tick();
        checks++; if (commit_store_vals !== 2'b00 || stq_count !== 3'd2) begin failures++; $display("FAIL dual_no_regrant got=%b/%0d exp=00/2", commit_store_vals, stq_count); end
        idle();
    endtask

    task automatic test_limit();
        do_reset();
        fill4();
        checks++; if (stq_count !== 3'd4 || stq_full !== 1'b0) begin failures++; $display("FAIL limit_fill got=%0d/%b exp=4/0", stq_count, stq_full); end
        set_head(4'd7, 2'b11, 2'b11, 2'b11);
        tick();
        checks++; if (commit_store_vals !== 2'b01 || commit_store_ids[0] !== 4'd7) begin failures++; $display("FAIL limit_one got=%b id=%0d exp=01 id=7", commit_store_vals, commit_store_ids[0]); end
        checks++; if (stq_count !== 3'd5 || stq_full !== 1'b1) begin failures++; $display("FAIL limit_full got=%0d/%b exp=5/1", stq_count, stq_full); end
        tick();
        checks++; if (commit_store_vals !== 2'b00) begin failures++; $display("FAIL limit_no_regrant got=%b exp=00", commit_store_vals); end
    endtask

    task automatic test_done_retire();
        set_head(4'd7, 2'b01, 2'b01, 2'b01);
        store_done_valid = 1'b1; store_done_tag = 4'd12;
        tick();
        store_done_valid = 1'b0;
        #1;
        checks++; if (store_retire_rdy !== 2'b00 || stq_count !== 3'd5) begin failures++; $display("FAIL done_nomatch got=%b/%0d exp=00/5", store_retire_rdy, stq_count); end
        store_done_valid = 1'b1; store_done_tag = 4'd7;
        tick();
        store_done_valid = 1'b0;
        #1;
        checks++; if (store_retire_rdy !== 2'b01) begin failures++; $display("FAIL done_rdy got=%b exp=01", store_retire_rdy); end
        set_head(4'd7, 2'b11, 2'b11, 2'b11);
        rob_retire = 2'b01;
        tick();
        rob_retire = 2'b00;
        checks++; if (stq_count !== 3'd4 || stq_full !== 1'b0) begin failures++; $display("FAIL retire_count got=%0d/%b exp=4/0", stq_count, stq_full); end
        checks++; if (commit_store_vals !== 2'b00) begin failures++; $display("FAIL retire_no_same_cycle_alloc got=%b exp=00", commit_store_vals); end
        set_head(4'd8, 2'b01, 2'b01, 2'b01);
        tick();
        checks++; if (commit_store_vals !== 2'b01 || commit_store_ids[0] !== 4'd8 || stq_count !== 3'd5) begin failures++; $display("FAIL realloc got=%b id=%0d cnt=%0d exp=01 id=8 cnt=5", commit_store_vals, commit_store_ids[0], stq_count); end
        set_head(4'd0, 2'b01, 2'b01, 2'b01);
        rob_retire = 2'b01;
        tick();
        rob_retire = 2'b00;
        checks++; if (stq_count !== 3'd5) begin failures++; $display("FAIL retire_not_done got=%0d exp=5", stq_count); end
        idle();
    endtask

    task automatic test_slot0_not_ready();
        do_reset();
        set_head(4'd3, 2'b11, 2'b11, 2'b10);
        tick();
        checks++; if (commit_store_vals !== 2'b00) begin failures++; $display("FAIL notready_c1 got=%b exp=00", commit_store_vals); end
        tick();
        checks++; if (commit_store_vals !== 2'b00 || stq_count !== 3'd0) begin failures++; $display("FAIL notready_c2 got=%b/%0d exp=00/0", commit_store_vals, stq_count); end
        head_ready = 2'b11;
        tick();
        checks++; if (commit_store_vals !== 2'b11 || commit_store_ids[1] !== 4'd4 || commit_store_ids[0] !== 4'd3) begin failures++; $display("FAIL notready_go got=%b ids=%0d,%0d exp=11 ids=4,3", commit_store_vals, commit_store_ids[1], commit_store_ids[0]); end
        idle();
    endtask

    task automatic test_one_free_slot1();
        do_reset();
        fill4();
        set_head(4'd10, 2'b11, 2'b10, 2'b10);
        tick();
        checks++; if (commit_store_vals !== 2'b10 || commit_store_ids[1] !== 4'd11 || stq_count !== 3'd5) begin failures++; $display("FAIL slot1_only got=%b id=%0d cnt=%0d exp=10 id=11 cnt=5", commit_store_vals, commit_store_ids[1], stq_count); end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        set_head(4'd0, 2'b11, 2'b11, 2'b11);
        tick();
        set_head(4'd5, 2'b01, 2'b01, 2'b01);
        tick();
        checks++; if (stq_count !== 3'd3) begin failures++; $display("FAIL flush_pre got=%0d exp=3", stq_count); end
        set_head(4'd9, 2'b11, 2'b11, 2'b11);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        checks++; if (commit_store_vals !== 2'b00 || stq_count !== 3'd0) begin failures++; $display("FAIL flush got=%b/%0d exp=00/0", commit_store_vals, stq_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        set_head(4'd15, 2'b11, 2'b11, 2'b11);
        tick();
        checks++; if (commit_store_vals !== 2'b11 || commit_store_ids[1] !== 4'd0 || commit_store_ids[0] !== 4'd15) begin failures++; $display("FAIL wrap got=%b ids=%0d,%0d exp=11 ids=0,15", commit_store_vals, commit_store_ids[1], commit_store_ids[0]); end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_dual_grant();
        test_limit();
        test_done_retire();
        test_slot0_not_ready();
        test_one_free_slot1();
        test_flush();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_commit_ctrl.md
STORE_COMMIT_CTRL -- requirements
Module: store_commit_ctrl

Interface
REQ-001 SHALL have parameter STQ_DEPTH, default 5, meaning the maximum number of granted-but-unretired stores.
REQ-002 SHALL have the port clk, input, 1 bit: the clock.
REQ-003 SHALL have the port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have the port flush, input, 1 bit: pipeline flush.
REQ-005 SHALL have the port rob_head, input, TAG_WIDTH bits: tag of ROB slot 0; slot 1 tag = rob_head+1, modulo 2^TAG_WIDTH.
REQ-006 SHALL have the ports head_valid, head_is_store and head_ready, input, PIPE_WIDTH bits each: per head slot, occupied / is a store / AGU and data complete.
REQ-007 SHALL have the ports store_done_valid (input, 1 bit) and store_done_tag (input, TAG_WIDTH bits): the store unit has written memory for that tag.
REQ-008 SHALL have the port rob_retire, input, PIPE_WIDTH bits: the ROB retires head slot i this cycle.
REQ-009 SHALL have the port commit_store_ids, output, array [PIPE_WIDTH] of TAG_WIDTH bits: granted store tags.
REQ-010 SHALL have the port commit_store_vals, output, PIPE_WIDTH bits: a grant pulse per lane.
REQ-011 SHALL have the port store_retire_rdy, output, PIPE_WIDTH bits: the head-slot store has completed and may retire.
REQ-012 SHALL have the ports stq_count (output, $clog2(STQ_DEPTH+1) bits: occupied entries) and stq_full (output, 1 bit: count == STQ_DEPTH).

Function
REQ-013 SHALL hold STQ_DEPTH entries {state, tag}, each in state FREE, GRANTED or DONE.
REQ-014 Slot 0 SHALL be grant-eligible when: head_valid[0], head_is_store[0] and head_ready[0] are set, no non-FREE entry holds its tag, and at least 1 entry is FREE.
REQ-015 Slot 1 SHALL be grant-eligible only under all of these conditions:
- its own REQ-014 conditions hold;
- slot 0 is a valid non-store, or slot 0 is already tracked, or slot 0 is granted this cycle;
- a second FREE entry exists when slot 0 is also granted this cycle.
REQ-016 SHALL register grants: an eligible slot i at cycle N SHALL drive commit_store_vals[i]=1 and commit_store_ids[i]=slot tag in cycle N+1, as a single-cycle pulse.
REQ-017 SHALL allocate the lowest-index FREE entry to slot 0 and the next-lowest to slot 1, moving each FREE->GRANTED at the grant edge.
REQ-018 SHALL never grant the same tag twice while its entry is non-FREE.
REQ-019 On store_done_valid with a matching GRANTED tag, SHALL move that entry GRANTED->DONE; a store_done with no match SHALL be ignored.
REQ-020 SHALL compute store_retire_rdy[i] combinationally, high only when head_valid[i], head_is_store[i] and an entry with the slot-i tag is DONE.
REQ-021 On rob_retire[i] with a DONE entry holding the slot-i tag, SHALL move that entry DONE->FREE at the edge; rob_retire on a non-store or a non-DONE store SHALL free nothing.
REQ-022 SHALL let allocation, DONE marking and freeing happen in the same cycle on different entries, with stq_count updated by the net change.
REQ-023 SHALL allow entries freed in cycle N to be allocated no earlier than cycle N+1.
REQ-024 SHALL size stq_count so it never wraps; at stq_full no grant SHALL issue, and with one FREE entry only slot 0 (or only slot 1 if slot 0 is ineligible) SHALL be granted.
REQ-025 On flush, SHALL set all entries FREE and force commit_store_vals=0 in the following cycle, overriding any same-cycle grant, done or retire.
REQ-026 Slot tag arithmetic SHALL wrap modulo 2^TAG_WIDTH, so that rob_head = all-ones gives slot 1 tag = 0.

Reset
REQ-027 In a cycle with rst high, SHALL set all entries FREE and drive commit_store_vals=0, commit_store_ids=0, stq_count=0 and stq_full=0 from the next edge.
REQ-028 Reset asserted mid-operation SHALL discard outstanding GRANTED/DONE entries with no grant pulse emitted.

Structure
REQ-029 SHALL take TAG_WIDTH and PIPE_WIDTH (=2) from uarch_pkg.
REQ-030 SHALL define the entry-state enum (FREE, GRANTED, DONE) and the entry struct in uarch_pkg.
REQ-031 SHALL be one flat module with no sub-modules, the entry table written as a generate or loop.

Verification
REQ-032 rob_head=7, slot 0 ready store, slot 1 ready store -> next cycle vals=2'b11, ids={8,7}, stq_count=2.
REQ-033 Slot 0 ready store, slot 1 ready store, count=4 -> vals=2'b01 only; in the following cycle with the same head, no second grant of tag 7.
REQ-034 After the grant of tag 7, store_done(7) -> store_retire_rdy[0]=1 next cycle; rob_retire[0] -> count decrements by 1.
REQ-035 Slot 0 a store with head_ready=0, slot 1 a ready store -> no grant on either lane until slot 0 is ready.
REQ-036 3 entries GRANTED, flush pulse at the same time as a new eligible store -> vals=0 next cycle and count=0.
REQ-037 rob_head=2^TAG_WIDTH-1, two ready stores -> ids={0, 2^TAG_WIDTH-1}.
